// File: rtl/lsu_pipelined_pkg.sv
// rtl/lsu_pipelined_pkg.sv - shared size codes, response metadata and load-alignment helper
package lsu_pipelined_pkg;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;
    localparam logic [1:0] MEM_D = 2'b11;

    // Everything needed to shape a read response once it returns
    typedef struct packed {
        logic [2:0] offset;   // byte offset within the bus word
        logic [2:0] opcode;   // {unsigned, size[1:0]}
    } lsu_meta_t;

    // Works on a 64-bit view of the bus word; narrower buses zero-extend in and truncate out
    function automatic logic [63:0] lsu_align_load(input logic [63:0] word, input lsu_meta_t meta);
        logic [63:0] sh;
        logic [63:0] res;
        sh = word >> {meta.offset, 3'b000};
        case (meta.opcode[1:0])
            MEM_B:   res = meta.opcode[2] ? {56'b0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            MEM_H:   res = meta.opcode[2] ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            MEM_W:   res = meta.opcode[2] ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_pipelined_if.sv
// rtl/lsu_pipelined_if.sv - Avalon-style data bus between the LSU and memory
interface lsu_pipelined_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    dbus_read;
    logic                    dbus_write;
    logic [ADDR_WIDTH-1:0]   dbus_address;
    logic [DATA_WIDTH-1:0]   dbus_writedata;
    logic [DATA_WIDTH/8-1:0] dbus_byte_enable;
    logic                    dbus_waitrequest;
    logic [DATA_WIDTH-1:0]   dbus_readdata;
    logic                    dbus_readdatavalid;

    modport master (
        output dbus_read, dbus_write, dbus_address, dbus_writedata, dbus_byte_enable,
        input  dbus_waitrequest, dbus_readdata, dbus_readdatavalid
    );

    modport slave (
        input  dbus_read, dbus_write, dbus_address, dbus_writedata, dbus_byte_enable,
        output dbus_waitrequest, dbus_readdata, dbus_readdatavalid
    );
endinterface

// File: rtl/lsu_pipelined_meta_fifo.sv
// rtl/lsu_pipelined_meta_fifo.sv - in-order metadata FIFO for outstanding reads
module lsu_pipelined_meta_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Full/empty come from the registered count, so a same-cycle pop never frees a slot for a push
    always_comb begin
        full     = (count == CW'(DEPTH));
        empty    = (count == '0);
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        pop_data = mem[rd_ptr];
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; entries are only read after being written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/lsu_pipelined.sv
// rtl/lsu_pipelined.sv - load/store unit with pipelined variable-latency bus reads
module lsu_pipelined
    import lsu_pipelined_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lsu_mem_read,
    input  logic                  lsu_mem_write,
    input  logic [2:0]            lsu_mem_opcode,
    input  logic [ADDR_WIDTH-1:0] lsu_address,
    input  logic [DATA_WIDTH-1:0] lsu_writedata,
    output logic                  lsu_stall,
    lsu_pipelined_if.master       dbus,
    output logic [DATA_WIDTH-1:0] lsu_readdata,
    output logic                  lsu_readdatavalid,
    output logic                  lsu_pending,
    output logic                  lsu_exception_load_addr_misaligned,
    output logic                  lsu_exception_store_addr_misaligned
);

    localparam int BEW    = DATA_WIDTH / 8;
    localparam int OFFW   = $clog2(BEW);
    localparam int CNTW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int META_W = $bits(lsu_meta_t);

    logic              misaligned;
    logic              accepted;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNTW-1:0]   fifo_count;
    logic [OFFW-1:0]   offset;
    logic [BEW-1:0]    be_mask;
    lsu_meta_t         push_meta;
    logic [META_W-1:0] head_bits;
    lsu_meta_t         head_meta;
    logic [63:0]       resp_word;
    logic [63:0]       resp_aligned;
    logic [DATA_WIDTH-1:0] resp_data;

    assign offset = lsu_address[OFFW-1:0];

    // Alignment check: address must be a multiple of the access size
    always_comb begin
        misaligned = 1'b0;
        case (lsu_mem_opcode[1:0])
            MEM_B:   misaligned = 1'b0;
            MEM_H:   misaligned = lsu_address[0];
            MEM_W:   misaligned = |lsu_address[1:0];
            default: misaligned = |lsu_address[2:0];
        endcase
    end

    // Issue, handshake and stall; misaligned requests never reach the bus and never stall
    always_comb begin
        dbus.dbus_read   = lsu_mem_read & ~misaligned & ~fifo_full;
        dbus.dbus_write  = lsu_mem_write & ~misaligned;
        dbus.dbus_address = {lsu_address[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
        accepted  = (dbus.dbus_read | dbus.dbus_write) & ~dbus.dbus_waitrequest;
        lsu_stall = (lsu_mem_read | lsu_mem_write) & ~misaligned & ~accepted;
        push      = dbus.dbus_read & ~dbus.dbus_waitrequest;
        lsu_exception_load_addr_misaligned  = lsu_mem_read & misaligned;
        lsu_exception_store_addr_misaligned = lsu_mem_write & misaligned;
    end

    // Lane enables and store-data replication so memory can pick the item from any lane
    always_comb begin
        be_mask             = BEW'(1);
        dbus.dbus_writedata = lsu_writedata;
        case (lsu_mem_opcode[1:0])
            MEM_B: begin
                be_mask             = BEW'(1);
                dbus.dbus_writedata = {BEW{lsu_writedata[7:0]}};
            end
            MEM_H: begin
                be_mask             = BEW'(3);
                dbus.dbus_writedata = {(DATA_WIDTH/16){lsu_writedata[15:0]}};
            end
            MEM_W: begin
                be_mask             = BEW'(15);
                dbus.dbus_writedata = {(DATA_WIDTH/32){lsu_writedata[31:0]}};
            end
            default: begin
                be_mask             = BEW'(8'hFF);
                dbus.dbus_writedata = lsu_writedata;
            end
        endcase
        dbus.dbus_byte_enable = be_mask << offset;
    end

    assign push_meta.offset = 3'(offset);
    assign push_meta.opcode = lsu_mem_opcode;

    lsu_pipelined_meta_fifo #(
        .WIDTH (META_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_meta_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_meta),
        .pop       (pop),
        .pop_data  (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A response with nothing outstanding is a bus protocol error and is simply dropped
    assign pop          = dbus.dbus_readdatavalid & ~fifo_empty;
    assign head_meta    = lsu_meta_t'(head_bits);
    assign resp_word    = 64'(dbus.dbus_readdata);
    assign resp_aligned = lsu_align_load(resp_word, head_meta);
    assign lsu_pending  = (fifo_count != '0);

    generate
        if (DATA_WIDTH == 64) begin : g_wide
            assign resp_data = resp_aligned;
        end else begin : g_narrow
            logic unused_hi;
            assign resp_data = resp_aligned[DATA_WIDTH-1:0];
            assign unused_hi = ^resp_aligned[63:DATA_WIDTH];
        end
    endgenerate

    // Registered load result: one pulse per popped response, data held between pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lsu_readdatavalid <= 1'b0;
            lsu_readdata      <= '0;
        end else begin
            lsu_readdatavalid <= pop;
            if (pop) lsu_readdata <= resp_data;
        end
    end

endmodule

// File: tb/tb_lsu_pipelined.sv
// tb/tb_lsu_pipelined.sv - directed self-checking bench for lsu_pipelined (32- and 64-bit builds)
module tb_lsu_pipelined;

    localparam logic [2:0] OP_LB = 3'b000, OP_LH = 3'b001, OP_LW = 3'b010, OP_LD = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100, OP_LHU = 3'b101, OP_LWU = 3'b110;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 32-bit instance
    logic        rd32, wr32;
    logic [2:0]  op32;
    logic [31:0] addr32, wd32, data32;
    logic        stall32, valid32, pend32, mld32, mst32;
    lsu_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus32();

    lsu_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_OUTSTANDING(4)) u_dut32 (
        .clk(clk), .rst(rst),
        .lsu_mem_read(rd32), .lsu_mem_write(wr32), .lsu_mem_opcode(op32),
        .lsu_address(addr32), .lsu_writedata(wd32), .lsu_stall(stall32),
        .dbus(bus32),
        .lsu_readdata(data32), .lsu_readdatavalid(valid32), .lsu_pending(pend32),
        .lsu_exception_load_addr_misaligned(mld32),
        .lsu_exception_store_addr_misaligned(mst32)
    );

    // 64-bit instance
    logic        rd64, wr64;
    logic [2:0]  op64;
    logic [31:0] addr64;
    logic [63:0] wd64, data64;
    logic        stall64, valid64, pend64, mld64, mst64;
    lsu_pipelined_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus64();

    lsu_pipelined #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .MAX_OUTSTANDING(4)) u_dut64 (
        .clk(clk), .rst(rst),
        .lsu_mem_read(rd64), .lsu_mem_write(wr64), .lsu_mem_opcode(op64),
        .lsu_address(addr64), .lsu_writedata(wd64), .lsu_stall(stall64),
        .dbus(bus64),
        .lsu_readdata(data64), .lsu_readdatavalid(valid64), .lsu_pending(pend64),
        .lsu_exception_load_addr_misaligned(mld64),
        .lsu_exception_store_addr_misaligned(mst64)
    );

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        wreq;
        logic [4:0]  exp_flags;   // {dbus_read, dbus_write, stall, load_mis, store_mis}
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic do_load32(input string nm, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] word, input logic [31:0] exp);
        @(negedge clk);
        rd32 = 1'b1; op32 = op; addr32 = a;
        @(negedge clk);
        rd32 = 1'b0;
        chk({nm, "_pending"}, 64'(pend32), 64'd1);
        bus32.dbus_readdatavalid = 1'b1; bus32.dbus_readdata = word;
        #1 chk({nm, "_no_early_valid"}, 64'(valid32), 64'd0);
        @(negedge clk);
        bus32.dbus_readdatavalid = 1'b0;
        chk({nm, "_valid"}, 64'(valid32), 64'd1);
        chk({nm, "_data"}, 64'(data32), 64'(exp));
        @(negedge clk);
        chk({nm, "_pulse_end"}, 64'(valid32), 64'd0);
    endtask

    task automatic do_load64(input string nm, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] exp_addr, input logic [7:0] exp_be,
                             input logic [63:0] word, input logic [63:0] exp);
        @(negedge clk);
        rd64 = 1'b1; op64 = op; addr64 = a;
        #1;
        chk({nm, "_addr"}, 64'(bus64.dbus_address), 64'(exp_addr));
        chk({nm, "_be"}, 64'(bus64.dbus_byte_enable), 64'(exp_be));
        @(negedge clk);
        rd64 = 1'b0;
        bus64.dbus_readdatavalid = 1'b1; bus64.dbus_readdata = word;
        @(negedge clk);
        bus64.dbus_readdatavalid = 1'b0;
        chk({nm, "_valid"}, 64'(valid64), 64'd1);
        chk({nm, "_data"}, data64, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"lb_1003",     1'b1, 1'b0, OP_LB,  32'h1003, 32'h0,        1'b0, 5'b10000, 32'h1000, 4'b1000, 32'h0000_0000};
        vecs[1]  = '{"sh_2002",     1'b0, 1'b1, OP_LH,  32'h2002, 32'hBEEF,     1'b0, 5'b01000, 32'h2000, 4'b1100, 32'hBEEF_BEEF};
        vecs[2]  = '{"sb_2001",     1'b0, 1'b1, OP_LB,  32'h2001, 32'h5A,       1'b0, 5'b01000, 32'h2000, 4'b0010, 32'h5A5A_5A5A};
        vecs[3]  = '{"sw_3000",     1'b0, 1'b1, OP_LW,  32'h3000, 32'h12345678, 1'b0, 5'b01000, 32'h3000, 4'b1111, 32'h1234_5678};
        vecs[4]  = '{"lw_1002_mis", 1'b1, 1'b0, OP_LW,  32'h1002, 32'h0,        1'b0, 5'b00010, 32'h0,    4'b0000, 32'h0};
        vecs[5]  = '{"sw_1001_mis", 1'b0, 1'b1, OP_LW,  32'h1001, 32'hDEAD,     1'b0, 5'b00001, 32'h0,    4'b0000, 32'h0};
        vecs[6]  = '{"lh_1001_mis", 1'b1, 1'b0, OP_LH,  32'h1001, 32'h0,        1'b0, 5'b00010, 32'h0,    4'b0000, 32'h0};
        vecs[7]  = '{"lhu_1002",    1'b1, 1'b0, OP_LHU, 32'h1002, 32'h0,        1'b0, 5'b10000, 32'h1000, 4'b1100, 32'h0};
        vecs[8]  = '{"lw_wait",     1'b1, 1'b0, OP_LW,  32'h0100, 32'h0,        1'b1, 5'b10100, 32'h0100, 4'b1111, 32'h0};
        vecs[9]  = '{"sw_wait",     1'b0, 1'b1, OP_LW,  32'h0204, 32'hA5A50F0F, 1'b1, 5'b01100, 32'h0204, 4'b1111, 32'hA5A5_0F0F};
        vecs[10] = '{"idle",        1'b0, 1'b0, OP_LB,  32'h0,    32'h0,        1'b0, 5'b00000, 32'h0,    4'b0000, 32'h0};
        vecs[11] = '{"sb_1003",     1'b0, 1'b1, OP_LB,  32'h1003, 32'h1234,     1'b0, 5'b01000, 32'h1000, 4'b1000, 32'h3434_3434};

        rd32 = 0; wr32 = 0; op32 = 0; addr32 = 0; wd32 = 0;
        bus32.dbus_waitrequest = 0; bus32.dbus_readdata = 0; bus32.dbus_readdatavalid = 0;
        rd64 = 0; wr64 = 0; op64 = 0; addr64 = 0; wd64 = 0;
        bus64.dbus_waitrequest = 0; bus64.dbus_readdata = 0; bus64.dbus_readdatavalid = 0;

        // Reset state
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("rst_valid32", 64'(valid32), 64'd0);
        chk("rst_data32", 64'(data32), 64'd0);
        chk("rst_pending32", 64'(pend32), 64'd0);
        chk("rst_valid64", 64'(valid64), 64'd0);
        chk("rst_pending64", 64'(pend64), 64'd0);
        chk("rst_no_strobe", 64'({bus32.dbus_read, bus32.dbus_write}), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Combinational issue vectors, each applied and withdrawn between two rising edges
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rd32 = vecs[i].rd; wr32 = vecs[i].wr; op32 = vecs[i].op;
            addr32 = vecs[i].addr; wd32 = vecs[i].wd; bus32.dbus_waitrequest = vecs[i].wreq;
            #1;
            chk({vecs[i].name, "_flags"},
                64'({bus32.dbus_read, bus32.dbus_write, stall32, mld32, mst32}), 64'(vecs[i].exp_flags));
            if (vecs[i].exp_flags[4] | vecs[i].exp_flags[3]) begin
                chk({vecs[i].name, "_addr"}, 64'(bus32.dbus_address), 64'(vecs[i].exp_addr));
                chk({vecs[i].name, "_be"}, 64'(bus32.dbus_byte_enable), 64'(vecs[i].exp_be));
                chk({vecs[i].name, "_wd"}, 64'(bus32.dbus_writedata), 64'(vecs[i].exp_wd));
            end
            rd32 = 0; wr32 = 0; bus32.dbus_waitrequest = 0;
        end
        chk("vec_no_pending", 64'(pend32), 64'd0);

        // Load extension and lane selection
        do_load32("lb_1003", OP_LB, 32'h1003, 32'h80FF_0000, 32'hFFFF_FF80);
        do_load32("lbu_1003", OP_LBU, 32'h1003, 32'h80FF_0000, 32'h0000_0080);
        do_load32("lh_1002", OP_LH, 32'h1002, 32'h80FF_0000, 32'hFFFF_80FF);
        do_load32("lhu_1002", OP_LHU, 32'h1002, 32'h80FF_0000, 32'h0000_80FF);
        do_load32("lb_1001", OP_LB, 32'h1001, 32'h0000_7F00, 32'h0000_007F);

        // Posted store: no FIFO entry, no response
        @(negedge clk);
        wr32 = 1; op32 = OP_LH; addr32 = 32'h2002; wd32 = 32'hBEEF;
        @(negedge clk);
        wr32 = 0;
        chk("sh_no_pending", 64'(pend32), 64'd0);
        @(negedge clk);
        chk("sh_no_valid", 64'(valid32), 64'd0);

        // Waitrequest held for three cycles
        @(negedge clk);
        rd32 = 1; op32 = OP_LW; addr32 = 32'h100; bus32.dbus_waitrequest = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("wait_stall_%0d", i), 64'(stall32), 64'd1);
            chk($sformatf("wait_hold_%0d", i), 64'({bus32.dbus_read, bus32.dbus_address}), 64'({1'b1, 32'h100}));
            chk($sformatf("wait_no_push_%0d", i), 64'(pend32), 64'd0);
            @(negedge clk);
        end
        bus32.dbus_waitrequest = 0;
        #1 chk("wait_release_stall", 64'(stall32), 64'd0);
        @(negedge clk);
        rd32 = 0;
        chk("wait_pending", 64'(pend32), 64'd1);
        bus32.dbus_readdatavalid = 1; bus32.dbus_readdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus32.dbus_readdatavalid = 0;
        chk("wait_valid", 64'(valid32), 64'd1);
        chk("wait_data", 64'(data32), 64'hCAFE_F00D);
        chk("wait_single_push", 64'(pend32), 64'd0);

        // Five back-to-back loads against a four-deep FIFO
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rd32 = 1; op32 = OP_LW; addr32 = 32'h400 + 32'(4 * i);
            #1 chk($sformatf("b2b_accept_%0d", i), 64'(stall32), 64'd0);
        end
        @(negedge clk);
        addr32 = 32'h410;
        #1;
        chk("full_stall", 64'(stall32), 64'd1);
        chk("full_no_read", 64'(bus32.dbus_read), 64'd0);
        @(negedge clk);
        chk("full_stall_hold", 64'(stall32), 64'd1);
        bus32.dbus_readdatavalid = 1; bus32.dbus_readdata = 32'h1000;
        #1 chk("full_pop_no_unblock", 64'(stall32), 64'd1);
        @(negedge clk);
        bus32.dbus_readdatavalid = 0;
        chk("full_resp0_valid", 64'(valid32), 64'd1);
        chk("full_resp0_data", 64'(data32), 64'h1000);
        #1;
        chk("full_release_stall", 64'(stall32), 64'd0);
        chk("full_release_read", 64'(bus32.dbus_read), 64'd1);
        @(negedge clk);
        rd32 = 0;
        for (int k = 1; k <= 4; k++) begin
            bus32.dbus_readdatavalid = 1; bus32.dbus_readdata = 32'h1000 + 32'(k);
            @(negedge clk);
            chk($sformatf("drain_valid_%0d", k), 64'(valid32), 64'd1);
            chk($sformatf("drain_data_%0d", k), 64'(data32), 64'(32'h1000 + 32'(k)));
        end
        bus32.dbus_readdatavalid = 0;
        chk("drain_empty", 64'(pend32), 64'd0);
        @(negedge clk);
        chk("drain_no_extra", 64'(valid32), 64'd0);

        // Push and pop in the same cycle
        @(negedge clk);
        rd32 = 1; op32 = OP_LW; addr32 = 32'h500;
        @(negedge clk);
        addr32 = 32'h504;
        bus32.dbus_readdatavalid = 1; bus32.dbus_readdata = 32'h2222;
        @(negedge clk);
        rd32 = 0;
        bus32.dbus_readdata = 32'h3333;
        chk("pp_valid0", 64'(valid32), 64'd1);
        chk("pp_data0", 64'(data32), 64'h2222);
        chk("pp_count_kept", 64'(pend32), 64'd1);
        @(negedge clk);
        bus32.dbus_readdatavalid = 0;
        chk("pp_valid1", 64'(valid32), 64'd1);
        chk("pp_data1", 64'(data32), 64'h3333);
        chk("pp_empty", 64'(pend32), 64'd0);

        // Response with nothing outstanding is dropped
        @(negedge clk);
        bus32.dbus_readdatavalid = 1; bus32.dbus_readdata = 32'h7777;
        @(negedge clk);
        bus32.dbus_readdatavalid = 0;
        chk("orphan_dropped", 64'(valid32), 64'd0);

        // 64-bit data path
        do_load64("lwu_8004", OP_LWU, 32'h8004, 32'h8000, 8'hF0, 64'hF000_0001_1234_5678, 64'h0000_0000_F000_0001);
        do_load64("lw_8004", OP_LW, 32'h8004, 32'h8000, 8'hF0, 64'hF000_0001_1234_5678, 64'hFFFF_FFFF_F000_0001);
        do_load64("ld_8008", OP_LD, 32'h8008, 32'h8008, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
        do_load64("lb_8007", OP_LB, 32'h8007, 32'h8000, 8'h80, 64'hF000_0001_1234_5678, 64'hFFFF_FFFF_FFFF_FFF0);
        @(negedge clk);
        wr64 = 1; op64 = OP_LD; addr64 = 32'h8010; wd64 = 64'h1122_3344_5566_7788;
        #1;
        chk("sd_be", 64'(bus64.dbus_byte_enable), 64'hFF);
        chk("sd_wd", bus64.dbus_writedata, 64'h1122_3344_5566_7788);
        op64 = OP_LW; addr64 = 32'h8014; wd64 = 64'h0000_0000_AABB_CCDD;
        #1;
        chk("sw64_be", 64'(bus64.dbus_byte_enable), 64'hF0);
        chk("sw64_wd", bus64.dbus_writedata, 64'hAABB_CCDD_AABB_CCDD);
        wr64 = 0; rd64 = 1; op64 = OP_LD; addr64 = 32'h8004;
        #1;
        chk("ld64_mis", 64'({mld64, bus64.dbus_read, stall64}), 64'b100);
        rd64 = 0;

        // Reset with two reads in flight
        @(negedge clk);
        rd32 = 1; op32 = OP_LW; addr32 = 32'h600;
        @(negedge clk);
        addr32 = 32'h604;
        @(negedge clk);
        rd32 = 0;
        chk("rst_mid_pending_before", 64'(pend32), 64'd1);
        rst = 0;
        #1 chk("rst_mid_pending_cleared", 64'(pend32), 64'd0);
        @(negedge clk);
        rst = 1;
        for (int k = 0; k < 2; k++) begin
            bus32.dbus_readdatavalid = 1; bus32.dbus_readdata = 32'h9000 + 32'(k);
            @(negedge clk);
            chk($sformatf("rst_mid_no_valid_%0d", k), 64'(valid32), 64'd0);
        end
        bus32.dbus_readdatavalid = 0;
        @(negedge clk);
        chk("rst_mid_no_valid_end", 64'(valid32), 64'd0);
        chk("rst_mid_pending_end", 64'(pend32), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
